output_port: RTL and testbench
==============================

OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO depth in flits (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 requestIn  input  5  bit i = request from input port i.
REQ-005 dataIn0..dataIn4  input  17 each  {valid, flit[15:0]} from input port i.
REQ-006 downReady  input  1  downstream accepts outData this cycle.
REQ-007 available  output  1  port free for a new packet (to every input's outputAvailable bit).
REQ-008 portReady  output  1  port can accept a flit this cycle (to every input's outputReady bit).
REQ-009 grant  output  5  one-hot owner of the port, all-zero when free.
REQ-010 outValid  output  1  outData holds a valid flit.
REQ-011 outData  output  16  flit at FIFO head.

Function
REQ-012 Flit type is flit[15:14]: 11 head (destination in [13:11]), 01 tail, 00/10 body.
REQ-013 The controller SHALL have two states: IDLE and ACTIVE.
REQ-014 In IDLE: available=1, grant=0, portReady=0.
REQ-015 IDLE with requestIn!=0: the winner is the first set bit searched from (lastWinner+1) mod 5 upward with wrap. Next cycle: state=ACTIVE, grant=onehot(winner), lastWinner=winner.
REQ-016 IDLE with requestIn=0: stay IDLE, lastWinner unchanged.
REQ-017 In ACTIVE: available=0, grant holds its value, portReady = !full.
REQ-018 Write SHALL occur only when ACTIVE, grant[k]=1, dataIn_k[16]=1 and !full; write dataIn_k[15:0] at the tail pointer.
REQ-019 Only the granted input's data is written. requestIn and data from other ports are ignored while ACTIVE.
REQ-020 Written flit of type tail: next cycle state=IDLE, grant=0, available=1.
REQ-021 A head written while ACTIVE is stored as data. It SHALL NOT change the owner.
REQ-022 Granted request dropping without a tail: remain ACTIVE, no write.
REQ-023 outValid = !empty; outData = FIFO head entry. Both are registered-state derived, with no combinational path from dataIn.
REQ-024 Pop when outValid & downReady.
REQ-025 Push and pop in the same cycle are both performed; count is unchanged.
REQ-026 Push is blocked when full, even if a pop occurs that cycle, because portReady depends on full only.
REQ-027 Count is 0..DEPTH: full = (count==DEPTH), empty = (count==0).
REQ-028 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 Arbitration latency: request in cycle n gives grant and portReady in cycle n+1 (if not full). Head written in n+1, visible on outData in n+2.
REQ-030 Tail written in cycle m: a new arbitration can start in cycle m+1 (IDLE), with grant at m+2.

Reset
REQ-031 On reset, independent of clk: state=IDLE, grant=0, available=1, portReady=0, lastWinner=4 (port 0 has first priority).
REQ-032 On reset: FIFO pointers and count = 0, outValid=0, outData=don't-care (implement as FIFO entry 0, contents not cleared).
REQ-033 Reset mid-packet drops all buffered flits and ownership. The first post-reset request is arbitrated per REQ-015.

Verification
REQ-034 Single packet: requestIn=00100, port 2 sends head 0xC800, body 0x0123, tail 0x4ABC with downReady=1. Required: grant=00100 one cycle after request; outData sequence C800, 0123, 4ABC; IDLE after tail; available=1.
REQ-035 Round-robin: requestIn=11111 held, each owner sends head+tail. Required grant order 00001, 00010, 00100, 01000, 10000, 00001.
REQ-036 Backpressure: downReady=0 with a 6-flit packet. Required: portReady=0 after 4 writes, count=4, no overwrite. Then downReady=1 gives all 6 flits in order.
REQ-037 Simultaneous push/pop at count=2. Required: count stays 2, order preserved across pointer wrap.
REQ-038 Non-owner interference: port 1 owns the port while port 3 drives valid flits and requestIn[3]=1. Required: none of port 3's flits appear on outData; port 3 is granted after port 1's tail.
REQ-039 Reset asserted asynchronously mid-packet with count=3. Required: immediately outValid=0, grant=0, available=1. After release, requestIn=01000 gives grant=01000.

Source files
------------

// File: rtl/output_port.sv
// Router output port: round-robin arbiter over five inputs feeding a small flit FIFO.
// States: IDLE = free, arbitrating requests | ACTIVE = owned by grant, accepting its flits.
module output_port #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  requestIn,
  input  logic [16:0] dataIn0,
  input  logic [16:0] dataIn1,
  input  logic [16:0] dataIn2,
  input  logic [16:0] dataIn3,
  input  logic [16:0] dataIn4,
  input  logic        downReady,
  output logic        available,
  output logic        portReady,
  output logic [4:0]  grant,
  output logic        outValid,
  output logic [15:0] outData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      grant_q, grant_d;
  logic [2:0]      last_q, last_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem [DEPTH];

  logic [16:0]     sel_data;
  logic [2:0]      winner;
  logic            found;
  int              idx;
  logic            full, empty, push, pop;

  // Grant is one-hot, so an AND-OR mux picks the owner's flit.
  assign sel_data = ({17{grant_q[0]}} & dataIn0) | ({17{grant_q[1]}} & dataIn1) |
                    ({17{grant_q[2]}} & dataIn2) | ({17{grant_q[3]}} & dataIn3) |
                    ({17{grant_q[4]}} & dataIn4);

  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= 5; i++) begin
      idx = (int'(last_q) + i) % 5;
      if (!found && requestIn[idx]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = (state_q == ACTIVE) && sel_data[16] && !full;
  assign pop   = !empty && downReady;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACTIVE;
          grant_d = 5'(5'b00001 << winner);
          last_d  = winner;
        end
      end
      ACTIVE: begin
        if (push && sel_data[15:14] == 2'b01) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 3'd4;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= sel_data[15:0];
  end

  assign available = (state_q == IDLE);
  assign portReady = (state_q == ACTIVE) && !full;
  assign grant     = grant_q;
  assign outValid  = !empty;
  assign outData   = mem[rd_ptr_q];

endmodule

// File: tb/tb_output_port.sv
// Randomized bench for output_port: packet-level reference model with a flit scoreboard.
module tb_output_port;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  req;
  logic [16:0] din [5];
  logic        down_ready;
  logic        available, portReady, outValid;
  logic [4:0]  grant;
  logic [15:0] outData;

  always #5 clk = ~clk;

  output_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .requestIn(req),
    .dataIn0(din[0]), .dataIn1(din[1]), .dataIn2(din[2]), .dataIn3(din[3]), .dataIn4(din[4]),
    .downReady(down_ready), .available(available), .portReady(portReady),
    .grant(grant), .outValid(outValid), .outData(outData)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] pq [5][$];
  bit          acc [5];
  int          bubble_pct = 0;
  bit          noise = 0;
  int          dr_mode = 1;
  logic [15:0] olog [$];
  logic [15:0] expl [$];
  logic [4:0]  glog [$];
  logic [4:0]  prev_grant = '0;

  logic [15:0] m_q [$];
  int          m_owner = -1;
  int          m_last = 4;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: port ownership plus a plain queue of accepted flits.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_owner = -1;
      m_last  = 4;
    end else begin
      bit          was_full;
      bit          got;
      logic [16:0] d;
      was_full = (m_q.size() == DEPTH);
      got = 0;
      if (m_q.size() > 0 && down_ready) void'(m_q.pop_front());
      if (m_owner < 0) begin
        for (int i = 1; i <= 5; i++) begin
          int p;
          p = (m_last + i) % 5;
          if (!got && req[p]) begin
            got = 1;
            m_owner = p;
            m_last  = p;
          end
        end
      end else begin
        d = din[m_owner];
        if (d[16] && !was_full) begin
          m_q.push_back(d[15:0]);
          if (d[15:14] == 2'b01) m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("available", 32'(available), 32'(m_owner < 0));
      check("portReady", 32'(portReady), 32'(m_owner >= 0 && m_q.size() < DEPTH));
      check("outValid", 32'(outValid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("outData", 32'(outData), 32'(m_q[0]));
      if (grant != 5'b0 && prev_grant == 5'b0) glog.push_back(grant);
      prev_grant = grant;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) if (acc[k]) void'(pq[k].pop_front());
    case (dr_mode)
      0: down_ready = 1'b0;
      1: down_ready = 1'b1;
      default: down_ready = 1'($urandom_range(0, 1));
    endcase
    for (int k = 0; k < 5; k++) begin
      if (pq[k].size() > 0) begin
        bit bub;
        bub = ($urandom_range(0, 99) < bubble_pct);
        din[k] = {~bub, pq[k][0]};
        req[k] = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        din[k] = {noise ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom)};
        req[k] = 1'b0;
      end
      acc[k] = din[k][16] && grant[k] && portReady;
    end
    if (outValid && down_ready) olog.push_back(outData);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 5; k++) begin
      pq[k].delete();
      acc[k] = 0;
      din[k] = '0;
    end
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    clear_stim();
    @(negedge clk);
    #1;
    reset = 1'b0;
    olog.delete();
    glog.delete();
    expl.delete();
  endtask

  task automatic drain(int maxc);
    int  n;
    bit  busy;
    n = 0;
    busy = 1;
    while (busy && n < maxc) begin
      step();
      n++;
      busy = (m_q.size() > 0) || (m_owner >= 0);
      for (int k = 0; k < 5; k++) if (pq[k].size() > 0) busy = 1;
    end
    check("drain_in_budget", 32'(busy), 32'd0);
  endtask

  task automatic add_pkt(int p, int nbody);
    pq[p].push_back({2'b11, 3'($urandom_range(0, 7)), 11'($urandom)});
    for (int i = 0; i < nbody; i++) begin
      int r;
      logic [1:0] t;
      r = $urandom_range(0, 9);
      t = (r < 5) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
      pq[p].push_back({t, 14'($urandom)});
    end
    pq[p].push_back({2'b01, 14'($urandom)});
  endtask

  task automatic compare_log(string name);
    check({name, "_len"}, 32'(olog.size()), 32'(expl.size()));
    for (int i = 0; i < expl.size() && i < olog.size(); i++)
      check(name, 32'(olog[i]), 32'(expl[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    down_ready = 1'b1;
    clear_stim();
    #1;
    check("rst_available", 32'(available), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_portReady", 32'(portReady), 32'd0);
    check("rst_outValid", 32'(outValid), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Single packet from port 2
    dr_mode = 1;
    pq[2].push_back(16'hC800);
    pq[2].push_back(16'h0123);
    pq[2].push_back(16'h4ABC);
    expl = '{16'hC800, 16'h0123, 16'h4ABC};
    step();
    check("single_grant_pre", 32'(grant), 32'd0);
    step();
    check("single_grant", 32'(grant), 32'h04);
    check("single_portReady", 32'(portReady), 32'd1);
    drain(50);
    compare_log("single_flit");
    check("single_idle_avail", 32'(available), 32'd1);

    // Round robin with all requests held
    do_reset();
    for (int p = 0; p < 5; p++) add_pkt(p, 0);
    add_pkt(0, 0);
    drain(100);
    check("rr_count", 32'(glog.size()), 32'd6);
    begin
      logic [4:0] rr_exp [6];
      rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      for (int i = 0; i < 6 && i < glog.size(); i++) check("rr_order", 32'(glog[i]), 32'(rr_exp[i]));
    end

    // Backpressure with a 6-flit packet
    do_reset();
    dr_mode = 0;
    add_pkt(0, 4);
    expl = pq[0];
    for (int i = 0; i < 10; i++) step();
    check("bp_portReady", 32'(portReady), 32'd0);
    check("bp_outValid", 32'(outValid), 32'd1);
    check("bp_head", 32'(outData), 32'(expl[0]));
    check("bp_pending", 32'(pq[0].size()), 32'd2);
    dr_mode = 1;
    drain(50);
    compare_log("bp_flit");

    // Port 3 drives flits while port 1 owns the output
    do_reset();
    add_pkt(1, 3);
    add_pkt(3, 1);
    expl = pq[1];
    foreach (pq[3][i]) expl.push_back(pq[3][i]);
    dr_mode = 2;
    drain(200);
    compare_log("nonowner_flit");
    check("nonowner_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("nonowner_first", 32'(glog[0]), 32'h02);
      check("nonowner_second", 32'(glog[1]), 32'h08);
    end

    // Asynchronous reset mid-packet with three flits buffered
    do_reset();
    dr_mode = 0;
    add_pkt(1, 4);
    begin
      int n;
      n = 0;
      while (m_q.size() != 3 && n < 20) begin
        step();
        n++;
      end
      check("mid_reached_3", 32'(m_q.size()), 32'd3);
    end
    check("mid_outValid_before", 32'(outValid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_outValid", 32'(outValid), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_available", 32'(available), 32'd1);
    check("mid_rst_portReady", 32'(portReady), 32'd0);
    clear_stim();
    @(negedge clk);
    #1;
    reset = 1'b0;
    dr_mode = 1;
    pq[3].push_back(16'hD000);
    pq[3].push_back(16'h4001);
    step();
    step();
    check("post_rst_grant", 32'(grant), 32'h08);
    drain(50);

    // Random traffic with bubbles, noise and random downstream stalls
    do_reset();
    noise = 1;
    bubble_pct = 20;
    dr_mode = 2;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 6) add_pkt($urandom_range(0, 4), $urandom_range(0, 5));
      step();
    end
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
